seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter CLK_DIV, default 1000, clock cycles per digit slot (legal range 4..65535).
REQ-002 Parameter BLANK_CYCLES, default 16, anti-ghosting cycles at slot start; SHALL satisfy 1 <= BLANK_CYCLES < CLK_DIV.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 value  in  16  four BCD nibbles; nibble k = value[4k+3:4k]; digit 0 is rightmost.
REQ-006 value_load  in  1  one-cycle strobe; captures value and dp_in into shadow.
REQ-007 dp_in  in  4  decimal-point request per digit, bit k = digit k.
REQ-008 lz_blank  in  1  leading-zero blanking enable, sampled live.
REQ-009 anodes  out  4  active-low digit enables, bit k = digit k.
REQ-010 segments  out  [0:6]  active-low segments a..g, index 0 = a.
REQ-011 dp_n  out  1  active-low decimal point.
REQ-012 frame_done  out  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-013 FSM states BLANK and ON; each slot = BLANK for BLANK_CYCLES cycles, then ON for CLK_DIV-BLANK_CYCLES cycles.
REQ-014 Slot counter runs 0..CLK_DIV-1 and wraps to 0; BLANK->ON at count BLANK_CYCLES-1; ON->BLANK at count CLK_DIV-1.
REQ-015 On ON->BLANK transition digit index increments 0->1->2->3->0 (wrap-around).
REQ-016 In BLANK: anodes=1111, segments=1111111, dp_n=1.
REQ-017 In ON: exactly one anode low (current index); segments = decode of active nibble; dp_n = ~active_dp[index].
REQ-018 Decode table (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-019 Nibbles 10..15 SHALL drive segments=1111111 (dark); dp unaffected.
REQ-020 All outputs registered; outputs reflect state/index one cycle after the FSM/counter transition.
REQ-021 Leading-zero blanking: with lz_blank=1, digit k (k=3..1) dark (segments=1111111, anode still low) when nibble k and all higher nibbles are 0; digit 0 never blanked; dp still shown.
REQ-022 value_load captures value/dp_in into shadow registers; last load before frame boundary wins.
REQ-023 Frame boundary = ON->BLANK transition of digit 3; shadow copied to active registers there; frame_done asserted for that one cycle.
REQ-024 value_load coincident with frame boundary: newly loaded value goes straight to active registers (bypass), not delayed a frame.
REQ-025 No load pending at boundary: active registers unchanged.

Reset
REQ-026 While rst=1: anodes=1111, segments=1111111, dp_n=1, frame_done=0.
REQ-027 Reset clears shadow, active, dp registers and pending flag to 0, digit index 0, counter 0, state BLANK.
REQ-028 Reset asserted mid-slot or mid-frame takes effect immediately; first slot after release is digit 0, starting in BLANK.

Structure
REQ-029 Segment decode table and state encoding SHALL live in shared package seg_pkg for reuse by other display blocks.
REQ-030 Slot counter and BLANK/ON phase generation SHALL be sub-module scan_prescaler (outputs slot_end, phase_on).
REQ-031 Decode, blanking and load/bypass logic stay in seven_seg_scanner; no other sub-modules.

Verification (CLK_DIV=8, BLANK_CYCLES=2)
REQ-032 Reset release, value_load with value=16'h1234, dp_in=0 -> after first boundary: digit0 anodes=1110 segments=1001100, digit3 anodes=0111 segments=1001111; each slot 2 dark + 6 lit cycles.
REQ-033 value=16'h0007, lz_blank=1 -> digits 3..1 segments=1111111 with anode low, digit 0 segments=0001111; lz_blank=0 -> digits 3..1 show 0000001.
REQ-034 value=16'h00AF, dp_in=4'b0010 -> digits 1,0 dark segments; dp_n=0 only in digit 1 ON phase.
REQ-035 Two loads (16'h1111 then 16'h2222) within one frame -> next frame shows 2222 only; load exactly on boundary cycle -> shown in immediately following frame; frame_done pulses once every 32 cycles.
REQ-036 rst asserted during digit 2 ON phase -> all outputs dark next edge (asynchronously); after release, digit 0 BLANK for 2 cycles, display shows 0.

Source files
------------

// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared seven-segment decode table and scan phase encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } scan_phase_e;

  localparam logic [0:6] SEG_DARK = 7'b1111111;

  // Active-low a..g; anything outside 0..9 stays dark.
  function automatic logic [0:6] seg_decode(input logic [3:0] nib);
    logic [0:6] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_DARK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
// ============================================================================
// Module   : scan_prescaler
// Purpose  : Per-digit slot counter with BLANK/ON phase generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_prescaler
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic phase_on
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  scan_phase_e   state_q, state_d;

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    case (state_q)
      PH_BLANK: if (cnt_q == CNT_BLANK_LAST) state_d = PH_ON;
      PH_ON:    if (cnt_q == CNT_LAST)       state_d = PH_BLANK;
      default:                               state_d = PH_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= PH_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign phase_on = (state_q == PH_ON);
  assign slot_end = (state_q == PH_ON) && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : 4-digit multiplexed BCD display driver with anti-ghost blanking,
//            leading-zero suppression and frame-synchronous value update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        value_load,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  anodes,
  output logic [0:6]  segments,
  output logic        dp_n,
  output logic        frame_done
);

  logic slot_end;
  logic phase_on;

  scan_prescaler #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .phase_on (phase_on)
  );

  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_dp_q,  shadow_dp_d;
  logic        pending_q,    pending_d;
  logic [15:0] active_val_q, active_val_d;
  logic [3:0]  active_dp_q,  active_dp_d;
  logic [1:0]  digit_idx_q,  digit_idx_d;
  logic [3:0]  anodes_q,     anodes_d;
  logic [0:6]  segments_q,   segments_d;
  logic        dp_n_q,       dp_n_d;
  logic        frame_done_q, frame_done_d;

  logic        frame_bound;
  logic [3:0]  active_nib;
  logic [3:0]  lead_zero;
  logic        blank_digit;

  assign frame_bound = slot_end && (digit_idx_q == 2'd3);

  // Shadow/active update: a load landing on the boundary bypasses the shadow.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    digit_idx_d  = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;

    if (value_load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    if (frame_bound) begin
      pending_d = 1'b0;
      if (value_load) begin
        active_val_d = value;
        active_dp_d  = dp_in;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
      end
    end
  end

  // lead_zero[k]: nibble k and every nibble above it are zero. Digit 0 never blanks.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (active_val_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (active_val_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (active_val_q[7:4]  == 4'd0);
    lead_zero[0] = 1'b0;
  end

  assign active_nib  = active_val_q[{digit_idx_q, 2'b00} +: 4];
  assign blank_digit = lz_blank && lead_zero[digit_idx_q];

  always_comb begin
    anodes_d     = 4'b1111;
    segments_d   = SEG_DARK;
    dp_n_d       = 1'b1;
    frame_done_d = frame_bound;
    if (phase_on) begin
      anodes_d   = ~(4'b0001 << digit_idx_q);
      segments_d = blank_digit ? SEG_DARK : seg_decode(active_nib);
      dp_n_d     = ~active_dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      digit_idx_q  <= '0;
      anodes_q     <= 4'b1111;
      segments_q   <= SEG_DARK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      digit_idx_q  <= digit_idx_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes     = anodes_q;
  assign segments   = segments_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Self-checking bench for seven_seg_scanner against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scanner;

  localparam int D     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        value_load;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  anodes;
  logic [0:6]  segments;
  logic        dp_n;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  // Model: m_n counts clock edges since reset release.
  int          m_n;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pend_v;
  logic [12:0] exp_o;

  logic [0:6] dec_tbl [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  seven_seg_scanner #(.CLK_DIV(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .value_load (value_load),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .anodes     (anodes),
    .segments   (segments),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_n = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pend_v = 0;
  endtask

  // Output after this edge follows from slot position, digit and frame contents.
  task automatic model_step();
    int pos, dig;
    logic [3:0] nib, an;
    logic [0:6] sg;
    logic dpn;
    bit dark, bound;
    pos   = m_n % D;
    dig   = (m_n / D) % 4;
    bound = (m_n % FRAME) == FRAME - 1;
    an = 4'hf; sg = 7'h7f; dpn = 1'b1;
    if (pos >= B) begin
      an[dig] = 1'b0;
      nib  = 4'((m_act >> (4 * dig)) & 16'hf);
      dark = (nib > 4'd9) || (lz_blank && dig != 0 && (m_act >> (4 * dig)) == 16'd0);
      sg   = dark ? 7'h7f : dec_tbl[nib];
      dpn  = ~m_act_dp[dig];
    end
    exp_o = {an, sg, dpn, bound};
    if (value_load) begin
      m_pend = value; m_pend_dp = dp_in; m_pend_v = 1;
    end
    if (bound && m_pend_v) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_pend_v = 0;
    end
    m_n++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    value_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; value = '0; value_load = 0; dp_in = '0; lz_blank = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({anodes, segments, dp_n, frame_done} !== 13'b1111_1111111_1_0) begin
      fails++;
      $display("FAIL reset_hold got=%b exp=%b", {anodes, segments, dp_n, frame_done}, 13'b1111_1111111_1_0);
    end
    rst = 1'b0;
    model_reset();
    tests++;
    if ({anodes, segments, dp_n, frame_done} !== 13'b1111_1111111_1_0) begin
      fails++;
      $display("FAIL reset_release got=%b exp=%b", {anodes, segments, dp_n, frame_done}, 13'b1111_1111111_1_0);
    end
  endtask

  task automatic test_value(input string name, input logic [15:0] v, input logic [3:0] d,
                            input logic lz, input int frames);
    value = v; dp_in = d; lz_blank = lz; value_load = 1'b1;
    for (int i = 0; i < frames * FRAME; i++) begin
      tick();
      tests++;
      if ({anodes, segments, dp_n, frame_done} !== exp_o) begin
        fails++;
        $display("FAIL %s edge=%0d got=%b exp=%b", name, m_n, {anodes, segments, dp_n, frame_done}, exp_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    lz_blank = 0; dp_in = 4'b0000;
    for (int i = 0; i < 4 * FRAME && (m_n % FRAME != 5 || i == 0); i++) tick();
    value = 16'h1111; value_load = 1'b1;
    tick();
    while (m_n % FRAME != 10) tick();
    value = 16'h2222; value_load = 1'b1;
    while (m_n % FRAME != FRAME - 1) begin
      tick();
      tests++;
      if ({anodes, segments, dp_n, frame_done} !== exp_o) begin
        fails++;
        $display("FAIL two_loads edge=%0d got=%b exp=%b", m_n, {anodes, segments, dp_n, frame_done}, exp_o);
      end
    end
    // Load lands exactly on the boundary cycle.
    value = 16'h3579; dp_in = 4'b1000; value_load = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      tests++;
      if ({anodes, segments, dp_n, frame_done} !== exp_o) begin
        fails++;
        $display("FAIL boundary_load edge=%0d got=%b exp=%b", m_n, {anodes, segments, dp_n, frame_done}, exp_o);
      end
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL frame_done_count got=%0d exp=%0d", pulses, 3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FRAME; i++) begin
      value_load = ($urandom_range(0, 6) == 0);
      value      = 16'($urandom);
      dp_in      = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
      tick();
      tests++;
      if ({anodes, segments, dp_n, frame_done} !== exp_o) begin
        fails++;
        $display("FAIL random edge=%0d got=%b exp=%b", m_n, {anodes, segments, dp_n, frame_done}, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    value = 16'h9876; dp_in = 4'b0100; lz_blank = 0; value_load = 1'b1;
    for (int i = 0; i < 3 * FRAME && (i < FRAME + 1 || m_n % FRAME != 2 * D + 5); i++) tick();
    tests++;
    if (anodes !== 4'b1011) begin
      fails++;
      $display("FAIL pre_reset_digit2 got=%b exp=%b", anodes, 4'b1011);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({anodes, segments, dp_n, frame_done} !== 13'b1111_1111111_1_0) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", {anodes, segments, dp_n, frame_done}, 13'b1111_1111111_1_0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      tests++;
      if ({anodes, segments, dp_n, frame_done} !== exp_o) begin
        fails++;
        $display("FAIL after_reset edge=%0d got=%b exp=%b", m_n, {anodes, segments, dp_n, frame_done}, exp_o);
      end
      if (i == 2) begin
        tests++;
        if ({anodes, segments} !== {4'b1110, 7'b0000001}) begin
          fails++;
          $display("FAIL first_lit_digit0 got=%b exp=%b", {anodes, segments}, {4'b1110, 7'b0000001});
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_value("value_1234", 16'h1234, 4'b0000, 1'b0, 3);
    test_value("lz_on_0007", 16'h0007, 4'b0000, 1'b1, 2);
    test_value("lz_off_0007", 16'h0007, 4'b0000, 1'b0, 2);
    test_value("hex_00AF", 16'h00AF, 4'b0010, 1'b0, 2);
    test_value("lz_dp_0100", 16'h0100, 4'b1111, 1'b1, 2);
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
